inertial_frame_loader: RTL and testbench

INERTIAL_FRAME_LOADER -- requirements
Module: inertial_frame_loader

---
 rtl/inertial_frame_loader.sv | 171 +++++++++++++++++
 tb/tb_inertial_frame_loader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inertial_frame_loader.sv
// Streams one frame of IMU samples into the network input memory, pulses start,
// waits for done and holds the captured position. INERTIAL_LOADER_TIMEOUT_EN adds a done watchdog.
module inertial_frame_loader #(
  parameter int DATA_WIDTH       = 16,
  parameter int INPUT_ADDR_WIDTH = 6,
  parameter int NUM_SAMPLES      = 60,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  input  logic [DATA_WIDTH-1:0]       s_data,
  output logic                        s_ready,
  output logic [INPUT_ADDR_WIDTH-1:0] input_write_address,
  output logic [DATA_WIDTH-1:0]       input_write_data,
  output logic                        input_write_enable,
  output logic                        start_inertial,
  input  logic                        done_inertial,
  input  logic [DATA_WIDTH-1:0]       X_position,
  input  logic [DATA_WIDTH-1:0]       y_position,
  input  logic [DATA_WIDTH-1:0]       z_position,
  output logic                        m_valid,
  output logic [DATA_WIDTH-1:0]       m_x,
  output logic [DATA_WIDTH-1:0]       m_y,
  output logic [DATA_WIDTH-1:0]       m_z,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        timeout_err
);

  if (NUM_SAMPLES < 1 || NUM_SAMPLES > (1 << INPUT_ADDR_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("inertial_frame_loader: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAIN, START, WAIT, CAPTURE, RESULT
  } state_t;

  localparam logic [INPUT_ADDR_WIDTH-1:0] LAST_ADDR = INPUT_ADDR_WIDTH'(NUM_SAMPLES - 1);

  state_t                        state_q, state_d;
  logic [INPUT_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                          s_ready_q, s_ready_d;
  logic                          we_q, we_d;
  logic [INPUT_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]         mx_q, mx_d, my_q, my_d, mz_q, mz_d;
  logic                          accept;
  logic                          last;
  logic                          tmo_hit;

  assign accept = s_valid & s_ready_q;
  assign last   = (cnt_q == LAST_ADDR);

`ifdef INERTIAL_LOADER_TIMEOUT_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic        err_q, err_d;

  always_comb begin
    tcnt_d  = tcnt_q;
    tmo_hit = 1'b0;
    if (state_q == START) begin
      tcnt_d = '0;
    end else if (state_q == WAIT) begin
      tcnt_d  = tcnt_q + 32'd1;
      tmo_hit = !done_inertial && (tcnt_d >= 32'(TIMEOUT_CYCLES));
    end
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (tmo_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    mx_d    = mx_q;
    my_d    = my_q;
    mz_d    = mz_q;

    if (accept) begin
      we_d    = 1'b1;
      waddr_d = cnt_q;
      wdata_d = s_data;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE:    if (accept) state_d = last ? DRAIN : LOAD;
      LOAD:    if (accept && last) state_d = DRAIN;
      DRAIN:   state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (done_inertial) begin
          state_d = CAPTURE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        mx_d    = X_position;
        my_d    = y_position;
        mz_d    = z_position;
        state_d = RESULT;
      end
      RESULT:  if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered from the next state so s_ready is low while in reset and
    // rises in the first cycle after release.
    s_ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      mz_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      mz_q      <= mz_d;
    end
  end

  assign s_ready             = s_ready_q;
  assign input_write_address = waddr_q;
  assign input_write_data    = wdata_q;
  assign input_write_enable  = we_q;
  assign start_inertial      = (state_q == START);
  assign m_valid             = (state_q == RESULT);
  assign m_x                 = mx_q;
  assign m_y                 = my_q;
  assign m_z                 = mz_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_inertial_frame_loader.sv
// Directed self-checking bench for inertial_frame_loader (60-sample frames).
module tb_inertial_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        done_inertial = 1'b0;
  logic [15:0] X_position = '0, y_position = '0, z_position = '0;
  logic        m_ready = 1'b0;

  logic        s_ready, input_write_enable, start_inertial, m_valid, busy, timeout_err;
  logic [5:0]  input_write_address;
  logic [15:0] input_write_data, m_x, m_y, m_z;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [21:0] wq[$];
  int          start_q[$];

  inertial_frame_loader #(
    .DATA_WIDTH(16),
    .INPUT_ADDR_WIDTH(6),
    .NUM_SAMPLES(60),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .input_write_address(input_write_address), .input_write_data(input_write_data),
    .input_write_enable(input_write_enable),
    .start_inertial(start_inertial), .done_inertial(done_inertial),
    .X_position(X_position), .y_position(y_position), .z_position(z_position),
    .m_valid(m_valid), .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_ready(m_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Write/start log sampled 1ns after each rising edge; cyc counts rising edges.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (input_write_enable === 1'b1) wq.push_back({input_write_address, input_write_data});
    if (start_inertial === 1'b1) start_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    step(2);
    n_checks++;
    if ({s_ready, input_write_enable, start_inertial, m_valid, busy, timeout_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000",
               {s_ready, input_write_enable, start_inertial, m_valid, busy, timeout_err});
    end
    n_checks++;
    if ({input_write_address, input_write_data} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_wr: got addr %h data %h expected 0/0", input_write_address, input_write_data);
    end
    n_checks++;
    if ({m_x, m_y, m_z} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_m: got %h %h %h expected 0", m_x, m_y, m_z);
    end
    rst_n = 1'b1;
    step(1);
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got s_ready %b busy %b expected 1/0", s_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    int hs;
    wq.delete();
    start_q.delete();
    hs = 0;
    for (int i = 0; i < 60; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i + 1);
      if (i == 59) hs = cyc;
      step(1);
    end
    s_valid = 1'b0;
    step(2);
    done_inertial = 1'b1;
    X_position = 16'h1111; y_position = 16'h2222; z_position = 16'h3333;
    step(1);
    done_inertial = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_capture_cycle: got m_valid %b expected 0", m_valid);
    end
    step(1);
    n_checks++;
    if (m_valid !== 1'b1 || cyc != hs + 5) begin
      n_fail++;
      $display("FAIL b2b_latency: got m_valid %b at cycle %0d expected 1 at %0d", m_valid, cyc, hs + 5);
    end
    n_checks++;
    if ({m_x, m_y, m_z} !== 48'h1111_2222_3333) begin
      n_fail++;
      $display("FAIL b2b_result: got %h %h %h expected 1111 2222 3333", m_x, m_y, m_z);
    end
    n_checks++;
    if (wq.size() != 60) begin
      n_fail++;
      $display("FAIL b2b_write_count: got %0d expected 60", wq.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        n_checks++;
        if (wq[i] !== {6'(i), 16'(i + 1)}) begin
          n_fail++;
          $display("FAIL b2b_write[%0d]: got %h expected %h", i, wq[i], {6'(i), 16'(i + 1)});
        end
      end
    end
    n_checks++;
    if (start_q.size() != 1 || start_q[0] != hs + 2) begin
      n_fail++;
      $display("FAIL b2b_start: got %0d pulses first at %0d expected 1 at %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, hs + 2);
    end
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_release: got busy %b m_valid %b expected 0/0", busy, m_valid);
    end
  endtask

  task automatic test_stall;
    logic [15:0] vals [3];
    vals = '{16'hFFFB, 16'h0007, 16'h8000};
    wq.delete();
    start_q.delete();
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = vals[k];
      step(1);
      s_valid = 1'b0;
      s_data  = 16'h5A5A;
      step(1);
    end
    step(1);
    n_checks++;
    if (wq.size() != 3) begin
      n_fail++;
      $display("FAIL stall_write_count: got %0d expected 3", wq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (wq[k] !== {6'(k), vals[k]}) begin
          n_fail++;
          $display("FAIL stall_write[%0d]: got %h expected %h", k, wq[k], {6'(k), vals[k]});
        end
      end
    end
  endtask

  task automatic test_spurious_load_done;
    done_inertial = 1'b1;
    step(2);
    done_inertial = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || m_valid !== 1'b0 || start_q.size() != 0) begin
      n_fail++;
      $display("FAIL load_done_ignored: got busy %b s_ready %b m_valid %b starts %0d expected 1/1/0/0",
               busy, s_ready, m_valid, start_q.size());
    end
    for (int i = 3; i < 60; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(16'h0100 + i);
      step(1);
    end
    s_valid = 1'b0;
    n_checks++;
    if (wq.size() != 60 || wq[wq.size() - 1] !== {6'd59, 16'h013B}) begin
      n_fail++;
      $display("FAIL load_rest: got %0d writes expected 60 ending at addr 59 data 013b", wq.size());
    end
  endtask

  task automatic test_start_done_ignored(output int st);
    step(1);
    st = cyc;
    n_checks++;
    if (start_inertial !== 1'b1) begin
      n_fail++;
      $display("FAIL start_pulse: got %b expected 1", start_inertial);
    end
    done_inertial = 1'b1;
    step(1);
    done_inertial = 1'b0;
    step(3);
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0 || start_inertial !== 1'b0) begin
      n_fail++;
      $display("FAIL start_done_ignored: got m_valid %b busy %b s_ready %b start %b expected 0/1/0/0",
               m_valid, busy, s_ready, start_inertial);
    end
  endtask

  task automatic test_spurious_wait_ready;
    m_ready = 1'b1;
    step(3);
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1 || m_x !== 16'h1111) begin
      n_fail++;
      $display("FAIL wait_ready_ignored: got m_valid %b busy %b m_x %h expected 0/1/1111", m_valid, busy, m_x);
    end
  endtask

  task automatic test_result_capture(input int st);
    while (cyc < st + 20) step(1);
    X_position = 16'h0123; y_position = 16'hFF00; z_position = 16'h7FFF;
    done_inertial = 1'b1;
    step(1);
    done_inertial = 1'b0;
    step(1);
    n_checks++;
    if (m_valid !== 1'b1 || {m_x, m_y, m_z} !== 48'h0123_FF00_7FFF) begin
      n_fail++;
      $display("FAIL capture: got m_valid %b %h %h %h expected 1 0123 ff00 7fff", m_valid, m_x, m_y, m_z);
    end
    X_position = 16'hDEAD; y_position = 16'hBEEF; z_position = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_checks++;
      if (m_valid !== 1'b1 || {m_x, m_y, m_z} !== 48'h0123_FF00_7FFF) begin
        n_fail++;
        $display("FAIL hold[%0d]: got m_valid %b %h %h %h expected 1 0123 ff00 7fff", i, m_valid, m_x, m_y, m_z);
      end
    end
  endtask

  task automatic test_ready_with_sample;
    wq.delete();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0AAA;
    step(1);
    m_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1 || wq.size() != 0) begin
      n_fail++;
      $display("FAIL result_exit: got busy %b m_valid %b s_ready %b writes %0d expected 0/0/1/0",
               busy, m_valid, s_ready, wq.size());
    end
    step(1);
    s_valid = 1'b0;
    n_checks++;
    if (wq.size() != 1 || wq[0] !== {6'd0, 16'h0AAA} || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_accept: got %0d writes busy %b expected 1 write 00/0aaa busy 1", wq.size(), busy);
    end
  endtask

  task automatic test_reset_midload;
    for (int i = 1; i < 30; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(16'h0200 + i);
      step(1);
    end
    s_valid = 1'b0;
    step(1);
    n_checks++;
    if (input_write_address !== 6'd29 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midload_addr: got %0d busy %b expected 29/1", input_write_address, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, input_write_enable, start_inertial, m_valid, busy, timeout_err,
         input_write_address, input_write_data, m_x, m_y, m_z} !== 76'h0) begin
      n_fail++;
      $display("FAIL midload_reset: got addr %h data %h m %h %h %h s_ready %b busy %b expected all 0",
               input_write_address, input_write_data, m_x, m_y, m_z, s_ready, busy);
    end
    step(1);
    rst_n = 1'b1;
    step(1);
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_release: got s_ready %b busy %b expected 1/0", s_ready, busy);
    end
    wq.delete();
    s_valid = 1'b1;
    s_data  = 16'h5555;
    step(1);
    s_valid = 1'b0;
    n_checks++;
    if (wq.size() != 1 || wq[0] !== {6'd0, 16'h5555}) begin
      n_fail++;
      $display("FAIL midload_restart: got %0d writes first %h expected 1 write 00/5555",
               wq.size(), (wq.size() > 0) ? wq[0] : 22'h0);
    end
  endtask

  task automatic test_timeout;
    int st;
    for (int i = 1; i < 60; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      step(1);
    end
    s_valid = 1'b0;
    step(1);
    st = cyc;
    n_checks++;
    if (start_inertial !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_start: got %b expected 1", start_inertial);
    end
`ifdef INERTIAL_LOADER_TIMEOUT_EN
    while (cyc < st + 50) step(1);
    n_checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_before: got busy %b err %b expected 1/0", busy, timeout_err);
    end
    step(1);
    n_checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: got busy %b err %b m_valid %b expected 0/1/0", busy, timeout_err, m_valid);
    end
    step(3);
    s_valid = 1'b1;
    s_data  = 16'h0042;
    step(1);
    s_valid = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: got %b expected 0", timeout_err);
    end
`else
    step(60);
    n_checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_forever: got busy %b err %b m_valid %b expected 1/0/0", busy, timeout_err, m_valid);
    end
    X_position = 16'h0A0B; y_position = 16'h0C0D; z_position = 16'h0E0F;
    done_inertial = 1'b1;
    step(1);
    done_inertial = 1'b0;
    step(1);
    n_checks++;
    if (m_valid !== 1'b1 || {m_x, m_y, m_z} !== 48'h0A0B_0C0D_0E0F) begin
      n_fail++;
      $display("FAIL late_done: got m_valid %b %h %h %h expected 1 0a0b 0c0d 0e0f", m_valid, m_x, m_y, m_z);
    end
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
`endif
  endtask

  initial begin
    int st;
    test_reset();
    test_back_to_back();
    test_stall();
    test_spurious_load_done();
    test_start_done_ignored(st);
    test_spurious_wait_ready();
    test_result_capture(st);
    test_ready_with_sample();
    test_reset_midload();
    test_timeout();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
